// File: rtl/fixed_normalizer_if.sv
// fixed_normalizer_if: sample-in / normalized-result-out bundle for fixed_normalizer.
interface fixed_normalizer_if #(
   parameter int IWIDTH = 6
);
   localparam int SWIDTH = (IWIDTH > 2) ? $clog2(IWIDTH) : 1;
   logic              clkena;
   logic              i_signed;
   logic [IWIDTH-1:0] i_data;
   logic              o_signed;
   logic [IWIDTH-1:0] o_data;
   logic [SWIDTH-1:0] o_shift;
   logic              o_zero;
   modport master (output clkena, i_signed, i_data, input o_signed, o_data, o_shift, o_zero);
   modport slave  (input clkena, i_signed, i_data, output o_signed, o_data, o_shift, o_zero);
endinterface

// File: rtl/fixed_normalizer.sv
// fixed_normalizer: left-normalizes a signed/unsigned fixed-point word and reports the shift,
// with a PIPELINE-deep clkena-qualified register chain on the result.
module fixed_normalizer #(
   parameter int IWIDTH   = 6,
   parameter int PIPELINE = 2
) (
   input logic               clk,
   input logic               reset,
   fixed_normalizer_if.slave nif
);
   localparam int SWIDTH = (IWIDTH > 2) ? $clog2(IWIDTH) : 1;
   localparam int W      = IWIDTH + SWIDTH + 2;

   logic [IWIDTH-1:0] v;
   logic [SWIDTH-1:0] sh;
   logic              zero;
   logic [W-1:0]      res;
   logic [W-1:0]      out;

   // Signed words are reduced to a leading-zero count on the sign-xored tail; the forced
   // LSB caps the count at IWIDTH-1 for all-sign-bit inputs such as -1.
   always_comb begin
      v = nif.i_signed ? {nif.i_data[IWIDTH-2:0] ^ {(IWIDTH-1){nif.i_data[IWIDTH-1]}}, 1'b1}
                       : nif.i_data;
      sh = '0;
      for (int i = 0; i < IWIDTH; i++) if (v[i]) sh = SWIDTH'(IWIDTH - 1 - i);
      zero = nif.i_data == '0;
      res = zero ? {nif.i_signed, 1'b1, {(IWIDTH + SWIDTH){1'b0}}}
                 : {nif.i_signed, 1'b0, nif.i_data << sh, sh};
   end

   if (PIPELINE == 0) begin : g_comb
      assign out = res;
   end else begin : g_pipe
      logic [W-1:0] pipe_q [PIPELINE];
      logic [W-1:0] pipe_d [PIPELINE];
      always_comb begin
         pipe_d[0] = nif.clkena ? res : pipe_q[0];
         for (int k = 1; k < PIPELINE; k++) pipe_d[k] = nif.clkena ? pipe_q[k-1] : pipe_q[k];
      end
      always_ff @(posedge clk or posedge reset)
         if (reset) pipe_q <= '{default: '0};
         else pipe_q <= pipe_d;
      assign out = pipe_q[PIPELINE-1];
   end

   assign {nif.o_signed, nif.o_zero, nif.o_data, nif.o_shift} = out;
endmodule

// File: tb/tb_fixed_normalizer.sv
// tb_fixed_normalizer: directed vectors, stall, async reset and a mixed-signedness sweep
// against hand-computed values and an iterative shift model.
module tb_fixed_normalizer;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   logic       sig_h [64];
   logic [5:0] dat_h [64];

   fixed_normalizer_if #(.IWIDTH(6)) nif ();
   fixed_normalizer #(.IWIDTH(6), .PIPELINE(2)) dut (.clk(clk), .reset(reset), .nif(nif));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic es, input logic [5:0] ed,
                      input logic [2:0] esh, input logic ez);
      checks++;
      assert ({nif.o_signed, nif.o_zero, nif.o_data, nif.o_shift} === {es, ez, ed, esh})
      else begin
         errors++;
         $error("FAIL %s: observed s=%b z=%b d=%b sh=%0d expected s=%b z=%b d=%b sh=%0d",
                tag, nif.o_signed, nif.o_zero, nif.o_data, nif.o_shift, es, ez, ed, esh);
      end
   endtask

   task automatic run(input string tag, input logic s, input logic [5:0] d,
                      input logic [5:0] ed, input logic [2:0] esh, input logic ez);
      nif.i_signed = s;
      nif.i_data   = d;
      @(negedge clk);
      @(negedge clk);
      chk(tag, s, ed, esh, ez);
   endtask

   function automatic void model(input logic s, input logic [5:0] d, output logic [5:0] od,
                                 output logic [2:0] osh, output logic oz);
      od  = d;
      osh = 3'd0;
      oz  = d == 6'd0;
      if (!oz)
         while (osh < 3'd5 && (s ? od[5] == od[4] : !od[5])) begin
            od  = od << 1;
            osh = osh + 3'd1;
         end
   endfunction

   initial begin
      logic [5:0] ed;
      logic [2:0] esh;
      logic       ez;
      int         lhs, rhs;
      reset = 1'b1;
      nif.clkena = 1'b1;
      nif.i_signed = 1'b0;
      nif.i_data = '0;
      repeat (2) @(negedge clk);
      chk("reset_state", 1'b0, 6'b000000, 3'd0, 1'b0);
      reset = 1'b0;
      run("u_000101", 1'b0, 6'b000101, 6'b101000, 3'd3, 1'b0);
      run("s_111010", 1'b1, 6'b111010, 6'b101000, 3'd2, 1'b0);
      run("s_000001", 1'b1, 6'b000001, 6'b010000, 3'd4, 1'b0);
      run("s_011111", 1'b1, 6'b011111, 6'b011111, 3'd0, 1'b0);
      run("s_100000", 1'b1, 6'b100000, 6'b100000, 3'd0, 1'b0);
      run("s_111111", 1'b1, 6'b111111, 6'b100000, 3'd5, 1'b0);
      run("u_zero",   1'b0, 6'b000000, 6'b000000, 3'd0, 1'b1);
      run("s_zero",   1'b1, 6'b000000, 6'b000000, 3'd0, 1'b1);
      run("u_100000", 1'b0, 6'b100000, 6'b100000, 3'd0, 1'b0);
      run("u_000001", 1'b0, 6'b000001, 6'b100000, 3'd5, 1'b0);
      // stall with X on the inputs: pipeline contents must hold untouched
      nif.i_signed = 1'b0;
      nif.i_data = 6'b000011;
      @(negedge clk);
      chk("one_edge", 1'b0, 6'b100000, 3'd5, 1'b0);
      nif.clkena = 1'b0;
      nif.i_signed = 1'bx;
      nif.i_data = 'x;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_hold", 1'b0, 6'b100000, 3'd5, 1'b0);
      end
      nif.clkena = 1'b1;
      nif.i_signed = 1'b0;
      nif.i_data = 6'b111111;
      @(negedge clk);
      chk("stall_result", 1'b0, 6'b110000, 3'd4, 1'b0);
      // async reset with a full pipeline
      nif.i_signed = 1'b1;
      nif.i_data = 6'b000001;
      @(negedge clk);
      nif.i_signed = 1'b0;
      nif.i_data = 6'b000101;
      @(negedge clk);
      #2 reset = 1'b1;
      #1 chk("async_reset", 1'b0, 6'b000000, 3'd0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      nif.i_signed = 1'b1;
      nif.i_data = 6'b111010;
      @(negedge clk);
      chk("no_leak", 1'b0, 6'b000000, 3'd0, 1'b0);
      @(negedge clk);
      chk("post_reset", 1'b1, 6'b101000, 3'd2, 1'b0);
      // sweep with signedness alternating each cycle
      for (int i = 0; i < 66; i++) begin
         if (i >= 2) begin
            model(sig_h[i-2], dat_h[i-2], ed, esh, ez);
            chk($sformatf("sweep_%0d", i - 2), sig_h[i-2], ed, esh, ez);
            if (sig_h[i-2]) begin
               lhs = int'($signed(nif.o_data));
               rhs = int'($signed(dat_h[i-2])) * (1 << nif.o_shift);
            end else begin
               lhs = int'(nif.o_data);
               rhs = int'(dat_h[i-2]) << nif.o_shift;
            end
            checks++;
            assert (lhs === rhs)
            else begin
               errors++;
               $error("FAIL invariant_%0d: observed %0d expected %0d", i - 2, lhs, rhs);
            end
         end
         if (i < 64) begin
            sig_h[i] = i[0];
            dat_h[i] = i[5:0];
            nif.i_signed = sig_h[i];
            nif.i_data = dat_h[i];
         end
         @(negedge clk);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
